bcd_counter_display: RTL and testbench
======================================

# bcd_counter_display

Parametrised successor to the two-digit run/pause counter. Counts a decimal value 0..MAX up or down in cascaded BCD digits at a prescaled tick rate, supports run/pause toggling, synchronous clear and direction control, and drives a scan-multiplexed common-cathode 7-segment display with optional leading-zero blanking. Sits between the debounce pulse generators (button inputs) and the board's digit/segment pins; `count_out` feeds the LED bar and other consumers.

## Interface
- DIGITS, 4: number of BCD digits and display positions, 1..8.
- MAX, 19: terminal count (decimal integer), 1..10^DIGITS-1; converted to BCD at elaboration.
- TICK_DIV, 100: clk cycles per count tick, >= 1.
- SCAN_DIV, 1: clk cycles each display position stays selected, >= 1.
- BLANK_LZ, 0: 1 = blank leading zero digits.

- clk  in  1  system clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- run_toggle  in  1  single-cycle pulse (from debounce); inverts run state.
- clear  in  1  synchronous clear of count and prescaler, level-sensitive.
- dir  in  1  1 = count up, 0 = count down; sampled on each tick.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- cat  out  DIGITS  digit select, active-low one-hot; bit 0 = least significant digit.
- count_out  out  4*DIGITS  current count, BCD, digit 0 in bits [3:0].
- wrap  out  1  one-cycle pulse when count wraps (MAX->0 up, 0->MAX down).
- running  out  1  current run state.

## Operation
- Reset (rst_n=0 at clk edge): count_out=0, running=1, prescaler=0, scan index=0, cat=all ones, seg=0, wrap=0.
- Prescaler: counts 0..TICK_DIV-1 only while running=1 and clear=0; generates internal tick in the cycle it equals TICK_DIV-1, then returns to 0. Frozen (not cleared) while paused.
- Count update on tick: up: if count==MAX then 0 with wrap=1, else BCD increment (digit 9 -> 0 carries). Down: if count==0 then MAX with wrap=1, else BCD decrement (digit 0 -> 9 borrows). Every digit of count_out always 0..9.
- Priority in one cycle: rst_n > clear > tick. clear forces count=0, prescaler=0, suppresses tick and wrap; running unchanged.
- run_toggle: running <= ~running. A tick in the same cycle still applies (decided by pre-toggle state). Ignored while clear=1? No: toggle is independent of clear.
- dir change takes effect on the next tick; no effect on prescaler.
- Display scan: index steps 0,1,..,DIGITS-1,0 every SCAN_DIV cycles, free-running from reset, independent of running/clear.
- cat[index]=0, others 1. seg = 7-segment code of count digit[index]: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- BLANK_LZ=1: digit i>0 shows seg=0000000 when it and all higher digits are 0; digit 0 always shown.

## Timing
- count_out, wrap, running are registered; count_out changes the clk edge after the tick cycle.
- With running=1 from reset and no clear: first update at edge TICK_DIV after reset release; then every TICK_DIV cycles.
- wrap high exactly in the cycle count_out shows the wrapped value.
- cat and seg registered together from the current index and count_out: 1-cycle display latency; they never disagree in the same cycle.
- First display selection (cat=...1110) appears on the first edge after reset release.
- TICK_DIV=1: tick every running cycle. SCAN_DIV=1: new position every cycle.

## Test plan
- Defaults, release reset, run 20*100 cycles -> count_out steps 0..19, wrap pulses once at 19->0 (cycle 2000), count 0.
- dir=0 from reset, TICK_DIV=1, MAX=19 -> first tick gives count=0x19 with wrap=1, then 0x18, 0x17.
- run_toggle pulse at prescaler 50 -> running=0, count frozen 500 cycles; second pulse -> next update exactly 50 cycles later.
- DIGITS=4, MAX=9999, up from 0x0999 -> 0x1000 with borrow/carry across three digits; down from 0x1000 -> 0x0999; no wrap pulse.
- clear asserted in same cycle as tick at count 7 -> count 0, wrap 0, prescaler 0, running unchanged; rst_n low mid-count -> all outputs to reset values next edge.
- BLANK_LZ=1, count 0x0042, DIGITS=4, SCAN_DIV=1 -> cat cycles 1110,1101,1011,0111 with seg 1100110(4)... order: digit0=1011011, digit1=1100110, digit2=0000000, digit3=0000000, each one cycle.

Source files
------------

// File: rtl/bcd_counter_display_if.sv
// Control and display signals of the BCD counter.
// The counter side uses the slave modport; whoever drives the buttons uses master.
interface bcd_counter_display_if #(
  parameter int DIGITS = 4
);
  logic                  run_toggle;
  logic                  clear;
  logic                  dir;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     cat;
  logic [4*DIGITS-1:0]   count_out;
  logic                  wrap;
  logic                  running;

  modport master (
    output run_toggle, clear, dir,
    input  seg, cat, count_out, wrap, running
  );

  modport slave (
    input  run_toggle, clear, dir,
    output seg, cat, count_out, wrap, running
  );
endinterface

// File: rtl/bcd_counter_display.sv
// Prescaled up/down BCD counter (0..MAX) with run/pause, clear and a
// scan-multiplexed common-cathode 7-segment driver.
module bcd_counter_display #(
  parameter int DIGITS   = 4,
  parameter int MAX      = 19,
  parameter int TICK_DIV = 100,
  parameter int SCAN_DIV = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_counter_display_if.slave bus
);
  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [CW-1:0] to_bcd(input int value);
    int v;
    v = value;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  logic [PW-1:0]     presc_reg;
  logic [CW-1:0]     count_reg;
  logic              wrap_reg;
  logic              running_reg;
  logic [SW-1:0]     scan_cnt_reg;
  logic [IW-1:0]     index_reg;
  logic [DIGITS-1:0] cat_reg;
  logic [6:0]        seg_reg;

  logic [3:0]        digit [DIGITS];
  logic [CW-1:0]     inc_next;
  logic [CW-1:0]     dec_next;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] borrow;
  logic [DIGITS-1:0] blank;
  logic              tick;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Ripple carry/borrow across digits: a digit rolls only when every lower digit rolls.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi] = count_reg[4*gi +: 4];
      assign inc_next[4*gi +: 4] = !carry[gi] ? digit[gi] :
                                   (digit[gi] == 4'd9) ? 4'd0 : digit[gi] + 4'd1;
      assign dec_next[4*gi +: 4] = !borrow[gi] ? digit[gi] :
                                   (digit[gi] == 4'd0) ? 4'd9 : digit[gi] - 4'd1;
      if (gi < DIGITS - 1) begin : g_chain
        assign carry[gi+1]  = carry[gi] & (digit[gi] == 4'd9);
        assign borrow[gi+1] = borrow[gi] & (digit[gi] == 4'd0);
      end
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (BLANK_LZ != 0) && (count_reg[CW-1:4*gi] == '0);
      end
    end
  endgenerate

  assign tick = running_reg & ~bus.clear & (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      count_reg    <= '0;
      wrap_reg     <= 1'b0;
      running_reg  <= 1'b1;
      scan_cnt_reg <= '0;
      index_reg    <= '0;
      cat_reg      <= '1;
      seg_reg      <= '0;
    end else begin
      running_reg <= running_reg ^ bus.run_toggle;
      wrap_reg    <= 1'b0;

      if (bus.clear) begin
        presc_reg <= '0;
        count_reg <= '0;
      end else if (running_reg) begin
        if (tick) begin
          presc_reg <= '0;
          if (bus.dir) begin
            if (count_reg == MAX_BCD) begin
              count_reg <= '0;
              wrap_reg  <= 1'b1;
            end else begin
              count_reg <= inc_next;
            end
          end else begin
            if (count_reg == '0) begin
              count_reg <= MAX_BCD;
              wrap_reg  <= 1'b1;
            end else begin
              count_reg <= dec_next;
            end
          end
        end else begin
          presc_reg <= presc_reg + PW'(1);
        end
      end

      // Display scan runs regardless of run/clear state.
      if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        index_reg    <= (index_reg == IW'(DIGITS - 1)) ? '0 : index_reg + IW'(1);
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SW'(1);
      end

      cat_reg <= ~(DIGITS'(1) << index_reg);
      seg_reg <= blank[index_reg] ? 7'b0000000 : seg_code(digit[index_reg]);
    end
  end

  assign bus.seg       = seg_reg;
  assign bus.cat       = cat_reg;
  assign bus.count_out = count_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.running   = running_reg;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Randomized bench: a cycle-level integer model of the counter and display
// is compared against every DUT output on each falling edge.
module tb_bcd_counter_display;
  localparam int DIGITS   = 3;
  localparam int MAX      = 105;
  localparam int TICK_DIV = 3;
  localparam int SCAN_DIV = 2;
  localparam int BLANK_LZ = 1;
  localparam int CYCLES   = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_counter_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter_display #(
    .DIGITS(DIGITS), .MAX(MAX), .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction

  function automatic logic [31:0] to_bcd(input int value);
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) to_bcd[4*i +: 4] = 4'((value / pow10(i)) % 10);
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] table_v [10];
    table_v = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    seg_of = table_v[d];
  endfunction

  // Reference state, held as plain integers.
  int                m_cnt, m_pre, m_idx, m_sc, m_wraps;
  bit                m_run, m_wrap;
  logic [DIGITS-1:0] m_cat;
  logic [6:0]        m_seg;

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_idx = 0; m_sc = 0;
    m_run = 1'b1; m_wrap = 1'b0;
    m_cat = '1; m_seg = '0;
  endtask

  task automatic step_model(input bit rn, input bit tg, input bit cl, input bit up, input int cyc);
    int  d;
    bit  blk;
    bit  tick;
    if (!rn) begin
      model_reset();
    end else begin
      d   = (m_cnt / pow10(m_idx)) % 10;
      blk = (BLANK_LZ != 0) && (m_idx > 0) && (m_cnt < pow10(m_idx));
      m_cat = ~(DIGITS'(1) << m_idx);
      m_seg = blk ? 7'b0 : seg_of(d);

      tick   = m_run && !cl && (m_pre == TICK_DIV - 1);
      m_wrap = 1'b0;
      if (cl) begin
        m_pre = 0;
        m_cnt = 0;
      end else if (m_run) begin
        m_pre = tick ? 0 : m_pre + 1;
      end
      if (tick) begin
        if (up) begin
          if (m_cnt == MAX) begin m_cnt = 0; m_wrap = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = MAX; m_wrap = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
        if (m_wrap) begin
          m_wraps++;
          $display("wrap cyc=%0d dir=%0d count=%0d", cyc, up, m_cnt);
        end
      end
      m_run = m_run ^ tg;

      if (m_sc == SCAN_DIV - 1) begin
        m_sc  = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_sc = m_sc + 1;
      end
    end
  endtask

  initial begin
    bus.run_toggle = 1'b0;
    bus.clear      = 1'b0;
    bus.dir        = 1'b1;
    rst_n          = 1'b0;
    m_wraps        = 0;
    model_reset();

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      check($sformatf("count_out c%0d", cyc), 32'(bus.count_out), to_bcd(m_cnt));
      check($sformatf("wrap c%0d", cyc),      32'(bus.wrap),      32'(m_wrap));
      check($sformatf("running c%0d", cyc),   32'(bus.running),   32'(m_run));
      check($sformatf("cat c%0d", cyc),       32'(bus.cat),       32'(m_cat));
      check($sformatf("seg c%0d", cyc),       32'(bus.seg),       32'(m_seg));

      rst_n          = (cyc < 2) ? 1'b0 : ($urandom_range(0, 5999) != 0);
      bus.run_toggle = ($urandom_range(0, 399) == 0);
      bus.clear      = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 799) == 0) bus.dir = ~bus.dir;

      step_model(rst_n, bus.run_toggle, bus.clear, bus.dir, cyc);
    end

    $display("wraps seen by model: %0d", m_wraps);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
